// File: rtl/gearbox_tx_if.sv
// rtl/gearbox_tx_if.sv - block-in / SERDES-word-out bundle for the transmit gearbox
interface gearbox_tx_if #(
    parameter int DATA_W  = 64,
    parameter int HEAD_W  = 2,
    parameter int BLOCK_W = DATA_W + HEAD_W,
    parameter int SEQ_W   = $clog2(DATA_W / HEAD_W + 1)
);
    logic [BLOCK_W-1:0] block_i;
    logic               full_o;
    logic [SEQ_W-1:0]   seq_o;
    logic               data_v_o;
    logic [DATA_W-1:0]  data_o;

    modport master (
        output block_i,
        input  full_o,
        input  seq_o,
        input  data_v_o,
        input  data_o
    );

    modport slave (
        input  block_i,
        output full_o,
        output seq_o,
        output data_v_o,
        output data_o
    );
endinterface

// File: rtl/gearbox_tx.sv
// rtl/gearbox_tx.sv - 66b block to 64b SERDES word transmit gearbox, 33-cycle sequence
module gearbox_tx #(
    parameter int DATA_W  = 64,
    parameter int HEAD_W  = 2,
    parameter int BLOCK_W = DATA_W + HEAD_W,
    parameter int SEQ_W   = $clog2(DATA_W / HEAD_W + 1)
) (
    input  logic         clk,
    input  logic         nreset,
    gearbox_tx_if.slave  gb
);
    localparam int SEQ_MAX = DATA_W / HEAD_W;
    localparam int CAT_W   = BLOCK_W + DATA_W - HEAD_W;

    logic [SEQ_W-1:0]  seq_q;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] data_q;
    logic              data_v_q;
    logic              full;
    logic [31:0]       shamt;
    logic [CAT_W-1:0]  cat;

    assign full  = (seq_q == SEQ_W'(SEQ_MAX));
    assign shamt = 32'(seq_q) * 32'(HEAD_W);

    // Residual bits above the valid count are always zero, so OR-ing the
    // shifted block over the residual is the same as concatenating them.
    always_comb begin
        cat = ({{(CAT_W-BLOCK_W){1'b0}}, gb.block_i} << shamt)
            | {{(CAT_W-DATA_W){1'b0}}, buf_q};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seq_q    <= '0;
            buf_q    <= '0;
            data_q   <= '0;
            data_v_q <= 1'b0;
        end else begin
            data_v_q <= 1'b1;
            if (full) begin
                data_q <= buf_q;
                buf_q  <= '0;
                seq_q  <= '0;
            end else begin
                data_q <= cat[DATA_W-1:0];
                buf_q  <= cat[CAT_W-1:DATA_W];
                seq_q  <= seq_q + SEQ_W'(1);
            end
        end
    end

    assign gb.full_o   = full;
    assign gb.seq_o    = seq_q;
    assign gb.data_o   = data_q;
    assign gb.data_v_o = data_v_q;

    seq_in_range: assert property (@(posedge clk) disable iff (!nreset) seq_q <= SEQ_W'(SEQ_MAX));
endmodule

// File: doc/gearbox_tx.md
# gearbox_tx

Transmit gearbox sitting directly downstream of the PCS transmit path. It converts the continuous stream of 66-bit scrambled, marked blocks (2-bit sync header + 64-bit payload) into a 64-bit SERDES word stream. It uses a 33-cycle sequence: 32 input blocks (2112 bits) are emitted as exactly 33 output words. During the 33rd cycle it asserts `full_o`, which the PCS uses to stall its pipeline and reset its sequence counter. One instance is used per lane (×1 for 10GBASE-R, ×4 for 40GBASE-R).

## Interface
Parameters:
- `DATA_W`, 64, payload width of a block and width of the output SERDES word.
- `HEAD_W`, 2, sync header width.
- `BLOCK_W`, `DATA_W+HEAD_W`, input block width.
- `SEQ_W`, `$clog2(DATA_W/HEAD_W+1)`, sequence counter width (6 for defaults).

Ports:
- `clk`  in  1  single clock.
- `nreset`  in  1  reset; asynchronous, active-low.
- `block_i`  in  `BLOCK_W`  block from the PCS. Sync header is in `[HEAD_W-1:0]`; the first transmitted bit is bit 0. Ignored while `full_o`=1.
- `full_o`  out  1  combinational. High when the current cycle does not consume `block_i`.
- `seq_o`  out  `SEQ_W`  current sequence value (0..32), for debug and formal checks.
- `data_v_o`  out  1  registered. High once the output word stream is valid.
- `data_o`  out  `DATA_W`  registered SERDES word. Bit 0 is transmitted first.

## Operation
- State:
  - `seq_q`: 0..32.
  - `buf_q`: `DATA_W` bits of residual, of which the low `HEAD_W*seq_q` bits are meaningful.
- When `seq_q` < 32:
  - Form `cat = {block_i, buf_q[HEAD_W*seq_q-1:0]}` (width `BLOCK_W + HEAD_W*seq_q`).
  - Next `data_o` = `cat[DATA_W-1:0]`.
  - Next `buf_q` = `cat >> DATA_W`, zero-extended. This leaves `HEAD_W*(seq_q+1)` valid bits.
  - `seq_q` increments.
- When `seq_q` == 32:
  - `full_o`=1 and `block_i` is ignored.
  - Next `data_o` = `buf_q` (all 64 bits valid).
  - Next `buf_q` = 0 and `seq_q` returns to 0.
- `full_o = (seq_q == 32)`. There is no other back-pressure: the block is free-running and must never idle.
- The variable-position select is implemented as a shift or mux over the 33 legal offsets. Offsets outside 0..64 are unreachable; `seq_q` > 32 is illegal and is covered by a formal assertion.
- Bit-order invariant: the concatenation of `data_o` words, LSB first, equals the concatenation of accepted `block_i` values, LSB first, with no bits dropped or duplicated.
- Reset (asynchronous assert):
  - `seq_q`=0, `buf_q`=0, `data_o`=0, `data_v_o`=0.
  - `full_o`=0 and `seq_o`=0 during reset.
- `data_v_o` rises on the first clock edge after reset release and then stays high.
- Reset asserted mid-sequence discards the residual bits. The first block after release starts a fresh aligned sequence at `seq_q`=0. The PCS resets in the same domain, so the two sequences stay aligned.

## Timing
- Latency is 1 cycle: the block accepted at edge N has its header bits appear in `data_o` after edge N+1 (for `seq_q`=0, at `data_o[1:0]`).
- `full_o` is valid in the same cycle as `seq_q`. The upstream presents a new block every cycle where `full_o`=0 and holds or ignores the cycle where `full_o`=1.
- Period is 33 cycles: `full_o` is high exactly one cycle in 33, first at cycle 32 after reset release (cycles counted from 0).
- `seq_o` and `full_o` reset immediately on `nreset` falling. Registered outputs update only on `clk` rising.

## Test plan
- Reset: hold `nreset`=0 with `block_i` toggling -> `data_o`=0, `data_v_o`=0, `seq_o`=0, `full_o`=0. After release, `data_v_o`=1 from the first edge.
- Seq 0 then seq 1:
  - Seq 0: `block_i`={64'hAAAA_AAAA_AAAA_AAAA, 2'b01} -> next `data_o`=64'hAAAA_AAAA_AAAA_AAA9, residual 2'b10.
  - Seq 1: `block_i`={64'h0, 2'b10} -> next `data_o`=64'h0000_0000_0000_000A.
- Full cadence: free-run 100 cycles -> `full_o` high at cycles 32, 65 and 98 only. `seq_o` wraps 32->0 and `data_o` is emitted in the full cycle.
- Bit integrity: 10 × 32 random blocks -> the output bitstream matches the input bitstream exactly, checked by a scoreboard with 66->64 reassembly.
- Mid-sequence reset: assert `nreset` at `seq_o`=17 for 1 cycle -> all state clears. After release, a block with header 2'b01 appears at `data_o[1:0]` one cycle after acceptance, and `full_o` next rises 32 cycles later.
- Last block before full: at `seq_o`=31 feed `block_i`={64'hFFFF_FFFF_FFFF_FFFF, 2'b10} -> next `data_o`[63:62]=2'b10 (header) and `data_o`[61:0] = the 62-bit residual. The following (full) cycle outputs 64'hFFFF_FFFF_FFFF_FFFF.
